// File: rtl/dac_pkg.sv
// Shared definitions for the AD5328 setpoint path: DAC word layout and the
// ramp controller state encoding.
package dac_pkg;

   localparam int DATA_W   = 12;
   localparam int ADDR_LSB = 12;
   localparam int ADDR_W   = 3;
   localparam int CTRL_BIT = 15;

   typedef enum logic [1:0] {
      S_STARTUP,
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

endpackage

// File: rtl/dac_ramp_ctrl.sv
// Slews the DAC code toward a clamped target in bounded steps, one formatted
// AD5328 write per step, with a fixed initial write after reset.
module dac_ramp_ctrl
   import dac_pkg::*;
#(
   parameter logic [2:0]  CHAN      = 3'd0,
   parameter int          STEP      = 16,
   parameter int          INTERVAL  = 2000,
   parameter int          STARTUP   = 200,
   parameter logic [11:0] INIT_CODE = 12'd0,
   parameter logic [11:0] CODE_MIN  = 12'd0,
   parameter logic [11:0] CODE_MAX  = 12'd4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        target_load,
   input  logic [15:0] target_value,
   output logic        dac_set,
   output logic [15:0] dac_value,
   output logic        busy,
   output logic        at_target
);

   localparam int          CNT_MAX  = (STARTUP > INTERVAL) ? STARTUP : INTERVAL;
   localparam int          CNT_W    = $clog2(CNT_MAX + 1);
   localparam logic [12:0] STEP_LIM = (STEP >= 4095) ? 13'd4095 : 13'(STEP);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [11:0]       cur_reg, cur_next;
   logic [11:0]       tgt_reg, tgt_next;
   logic              dac_set_next, at_target_next;
   logic [15:0]       dac_value_next;

   logic [11:0] req_code, lo_clamped, clamped;
   logic [12:0] up_diff, down_diff, up_step, down_step;
   logic [11:0] step_code;

   assign req_code = target_value[11:0];

   // Clamp comparisons are only built when the bound is not the full range.
   generate
      if (CODE_MIN == 12'd0) begin : g_no_min
         assign lo_clamped = req_code;
      end else begin : g_min
         assign lo_clamped = (req_code < CODE_MIN) ? CODE_MIN : req_code;
      end
      if (CODE_MAX == 12'd4095) begin : g_no_max
         assign clamped = lo_clamped;
      end else begin : g_max
         assign clamped = (lo_clamped > CODE_MAX) ? CODE_MAX : lo_clamped;
      end
   endgenerate

   // 13-bit differences so the final step lands on the target without wrap.
   assign up_diff   = {1'b0, tgt_reg} - {1'b0, cur_reg};
   assign down_diff = {1'b0, cur_reg} - {1'b0, tgt_reg};
   assign up_step   = (up_diff > STEP_LIM) ? STEP_LIM : up_diff;
   assign down_step = (down_diff > STEP_LIM) ? STEP_LIM : down_diff;

   always_comb begin
      step_code = cur_reg;
      if (tgt_reg > cur_reg) begin
         step_code = 12'({1'b0, cur_reg} + up_step);
      end else if (tgt_reg < cur_reg) begin
         step_code = 12'({1'b0, cur_reg} - down_step);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_STARTUP;
         cnt_reg   <= '0;
         cur_reg   <= INIT_CODE;
         tgt_reg   <= INIT_CODE;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cur_reg   <= cur_next;
         tgt_reg   <= tgt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cur_next   = cur_reg;
      tgt_next   = target_load ? clamped : tgt_reg;
      case (state_reg)
         S_STARTUP: begin
            if (cnt_reg == CNT_W'(STARTUP - 1)) begin
               state_next = S_ISSUE;
               cnt_next   = '0;
               cur_next   = INIT_CODE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_IDLE: begin
            if (cur_reg != tgt_reg) begin
               state_next = S_ISSUE;
               cur_next   = step_code;
            end
         end
         S_ISSUE: begin
            state_next = S_WAIT;
            cnt_next   = '0;
         end
         S_WAIT: begin
            if (cnt_reg == CNT_W'(INTERVAL - 1)) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = S_STARTUP;
      endcase
   end

   // Outputs are derived from next-state values so every flag is registered.
   always_comb begin
      dac_set_next   = (state_next == S_ISSUE);
      at_target_next = (state_next == S_IDLE) && (cur_next == tgt_next);
      dac_value_next = '0;
      dac_value_next[CTRL_BIT]              = 1'b0;
      dac_value_next[ADDR_LSB +: ADDR_W]    = CHAN;
      dac_value_next[DATA_W-1:0]            = cur_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_set   <= 1'b0;
         dac_value <= {1'b0, CHAN, INIT_CODE};
         busy      <= 1'b1;
         at_target <= 1'b0;
      end else begin
         dac_set   <= dac_set_next;
         dac_value <= dac_value_next;
         busy      <= ~at_target_next;
         at_target <= at_target_next;
      end
   end

endmodule
